// File: rtl/cpu_pkg.sv
// Shared CPU types: ROB tag / result widths and functional-unit source encoding.
package cpu_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    typedef enum logic {
        ADD = 1'b0,
        MUL = 1'b1
    } fu_src_t;

endpackage

// File: rtl/result_fifo.sv
// Per-FU result queue of {tag,value} entries with registered occupancy count.
module result_fifo
    import cpu_pkg::*;
#(
    parameter int TAG_W  = cpu_pkg::TAG_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic              ready,
    output logic              not_empty,
    output logic [TAG_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_value
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign ready      = (count_q < CNT_W'(DEPTH));
    assign not_empty  = (count_q != '0);
    assign head_tag   = mem_q[rd_ptr_q].tag;
    assign head_value = mem_q[rd_ptr_q].value;

    assign do_push = push_valid & ready & ~flush;
    assign do_pop  = pop & not_empty & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = '{tag: push_tag, value: push_value};
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two FU result queues, round-robin grant, registered CDB outputs.
module cdb_arbiter
    import cpu_pkg::*;
#(
    parameter int TAG_W  = cpu_pkg::TAG_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              add_valid,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_value,
    output logic              add_ready,
    input  logic              mul_valid,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_value,
    output logic              mul_ready,
    input  logic              flush,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic              cdb_src
);

    logic              add_ne, mul_ne;
    logic [TAG_W-1:0]  add_head_tag, mul_head_tag;
    logic [DATA_W-1:0] add_head_value, mul_head_value;
    logic              grant_add, grant_mul;

    fu_src_t           last_grant_q, last_grant_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    fu_src_t           cdb_src_q, cdb_src_d;

    result_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_add_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (add_valid),
        .push_tag   (add_tag),
        .push_value (add_value),
        .pop        (grant_add),
        .ready      (add_ready),
        .not_empty  (add_ne),
        .head_tag   (add_head_tag),
        .head_value (add_head_value)
    );

    result_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mul_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (mul_valid),
        .push_tag   (mul_tag),
        .push_value (mul_value),
        .pop        (grant_mul),
        .ready      (mul_ready),
        .not_empty  (mul_ne),
        .head_tag   (mul_head_tag),
        .head_value (mul_head_value)
    );

    // On a tie the source that did not win last time is served.
    assign grant_add = ~flush & add_ne & (~mul_ne | (last_grant_q == MUL));
    assign grant_mul = ~flush & mul_ne & (~add_ne | (last_grant_q == ADD));

    always_comb begin
        last_grant_d = last_grant_q;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = cdb_tag_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        if (grant_add) begin
            last_grant_d = ADD;
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = add_head_tag;
            cdb_value_d  = add_head_value;
            cdb_src_d    = ADD;
        end else if (grant_mul) begin
            last_grant_d = MUL;
            cdb_valid_d  = 1'b1;
            cdb_tag_d    = mul_head_tag;
            cdb_value_d  = mul_head_value;
            cdb_src_d    = MUL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= MUL;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= ADD;
        end else begin
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomised checks of cdb_arbiter with an independent queue/round-robin model.
module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        add_valid, mul_valid, flush;
    logic [2:0]  add_tag, mul_tag;
    logic [31:0] add_value, mul_value;
    logic        add_ready, mul_ready;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_src;

    int checks = 0;
    int errors = 0;

    logic [34:0] qa[$];
    logic [34:0] qm[$];
    logic        mlast;
    int          wa, wm;

    cdb_arbiter #(
        .TAG_W  (3),
        .DATA_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .add_valid (add_valid),
        .add_tag   (add_tag),
        .add_value (add_value),
        .add_ready (add_ready),
        .mul_valid (mul_valid),
        .mul_tag   (mul_tag),
        .mul_value (mul_value),
        .mul_ready (mul_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic [2:0] ta, input logic [31:0] xa,
                         input logic vm, input logic [2:0] tm, input logic [31:0] xm);
        add_valid = va; add_tag = ta; add_value = xa;
        mul_valid = vm; mul_tag = tm; mul_value = xm;
    endtask

    task automatic chk_cdb(input string tag, input logic [2:0] t, input logic [31:0] v, input logic s);
        chk({tag, "_valid"}, cdb_valid, 1'b1);
        chk({tag, "_tag"}, cdb_tag, t);
        chk({tag, "_value"}, cdb_value, v);
        chk({tag, "_src"}, cdb_src, s);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        step();
        reset = 1'b1;
    endtask

    // One random/drain cycle checked against the model queues and round-robin state.
    task automatic run_cycle(input logic va, input logic [2:0] ta, input logic [31:0] xa,
                             input logic vm, input logic [2:0] tm, input logic [31:0] xm);
        logic acc_a, acc_m, ne_a, ne_m, ga, gm;
        logic [34:0] e;
        chk("rnd_add_ready", add_ready, (qa.size() < DEPTH));
        chk("rnd_mul_ready", mul_ready, (qm.size() < DEPTH));
        drive(va, ta, xa, vm, tm, xm);
        acc_a = va && (qa.size() < DEPTH);
        acc_m = vm && (qm.size() < DEPTH);
        step();
        ne_a = qa.size() > 0;
        ne_m = qm.size() > 0;
        ga = ne_a && (!ne_m || mlast);
        gm = ne_m && (!ne_a || !mlast);
        chk("rnd_cdb_valid", cdb_valid, ga || gm);
        if (ga) begin
            e = qa.pop_front();
            chk_cdb("rnd_add", e[34:32], e[31:0], 1'b0);
            mlast = 1'b0;
            wa = 0;
        end else if (ne_a) begin
            wa++;
        end
        if (gm) begin
            e = qm.pop_front();
            chk_cdb("rnd_mul", e[34:32], e[31:0], 1'b1);
            mlast = 1'b1;
            wm = 0;
        end else if (ne_m) begin
            wm++;
        end
        chk("rnd_starve", (wa < 2) && (wm < 2), 1'b1);
        if (acc_a) qa.push_back({ta, xa});
        if (acc_m) qm.push_back({tm, xm});
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_valid", cdb_valid, 1'b0);
        chk("rst_tag", cdb_tag, 3'd0);
        chk("rst_value", cdb_value, 32'd0);
        chk("rst_src", cdb_src, 1'b0);
        chk("rst_add_ready", add_ready, 1'b1);
        chk("rst_mul_ready", mul_ready, 1'b1);
        step();
        reset = 1'b1;

        // Single ADD result
        drive(1, 3'd3, 32'd17, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("single_lat", cdb_valid, 1'b0);
        step();
        chk_cdb("single", 3'd3, 32'd17, 1'b0);
        step();
        chk("single_idle", cdb_valid, 1'b0);
        chk("single_hold_tag", cdb_tag, 3'd3);

        // Tie after reset: ADD first
        do_reset();
        drive(1, 3'd1, 32'd5, 1, 3'd2, 32'd6);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("tie_lat", cdb_valid, 1'b0);
        step();
        chk_cdb("tie_add", 3'd1, 32'd5, 1'b0);
        step();
        chk_cdb("tie_mul", 3'd2, 32'd6, 1'b1);
        step();
        chk("tie_idle", cdb_valid, 1'b0);

        // Backpressure on MUL
        do_reset();
        drive(1, 3'd0, 32'd100, 1, 3'd4, 32'd40);
        step();
        drive(1, 3'd1, 32'd101, 1, 3'd5, 32'd50);
        step();
        chk_cdb("bp_e2", 3'd0, 32'd100, 1'b0);
        chk("bp_mul_full", mul_ready, 1'b0);
        drive(1, 3'd2, 32'd102, 1, 3'd6, 32'd60);
        step();
        chk_cdb("bp_e3", 3'd4, 32'd40, 1'b1);
        chk("bp_mul_free", mul_ready, 1'b1);
        drive(0, 0, 0, 1, 3'd6, 32'd60);
        step();
        chk_cdb("bp_e4", 3'd1, 32'd101, 1'b0);
        chk("bp_mul_full2", mul_ready, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("bp_e5", 3'd5, 32'd50, 1'b1);
        step();
        chk_cdb("bp_e6", 3'd2, 32'd102, 1'b0);
        step();
        chk_cdb("bp_e7", 3'd6, 32'd60, 1'b1);
        step();
        chk("bp_idle", cdb_valid, 1'b0);

        // Flush with both queues occupied
        do_reset();
        drive(1, 3'd1, 32'd1, 1, 3'd2, 32'd2);
        step();
        drive(1, 3'd3, 32'd3, 1, 3'd4, 32'd4);
        step();
        chk_cdb("fl_e2", 3'd1, 32'd1, 1'b0);
        chk("fl_mul_full", mul_ready, 1'b0);
        drive(1, 3'd5, 32'd5, 1, 3'd6, 32'd6);
        step();
        chk_cdb("fl_e3", 3'd2, 32'd2, 1'b1);
        chk("fl_add_full", add_ready, 1'b0);
        drive(1, 3'd7, 32'd7, 1, 3'd6, 32'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_valid", cdb_valid, 1'b0);
        chk("fl_add_ready", add_ready, 1'b1);
        chk("fl_mul_ready", mul_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_stale", cdb_valid, 1'b0);
        end

        // Asynchronous reset mid-operation
        do_reset();
        drive(1, 3'd1, 32'd11, 1, 3'd2, 32'd22);
        step();
        drive(1, 3'd3, 32'd33, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk_cdb("ar_pre", 3'd1, 32'd11, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", cdb_valid, 1'b0);
        chk("ar_tag", cdb_tag, 3'd0);
        chk("ar_value", cdb_value, 32'd0);
        chk("ar_add_ready", add_ready, 1'b1);
        chk("ar_mul_ready", mul_ready, 1'b1);
        drive(1, 3'd7, 32'd77, 0, 0, 0);
        #2;
        reset = 1'b1;
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("ar_no_stale", cdb_valid, 1'b0);
        step();
        chk_cdb("ar_first", 3'd7, 32'd77, 1'b0);
        step();
        chk("ar_idle", cdb_valid, 1'b0);

        // Random streams against the model
        do_reset();
        mlast = 1'b1;
        wa = 0;
        wm = 0;
        for (int i = 0; i < 1000; i++) begin
            run_cycle($urandom_range(0, 3) != 0, 3'($urandom), $urandom,
                      $urandom_range(0, 3) != 0, 3'($urandom), $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0);
        end
        chk("drain_empty", qa.size() + qm.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
